wb_stg: RTL and testbench
=========================

Name: wb_stg

Overview:
- Writeback stage directly upstream of the register file; the only producer of `reg_file_wr_req_vld` / `reg_file_wr_req_pkt`.
- Merges two result sources:
  - in-order pipeline results from the memory stage (ALU results and load data);
  - out-of-band results from the long-latency multiply/divide unit (GPR-writing MUL).
- Performs big-endian load extraction and sign/zero extension.
- Buffers multiply/divide results in a 2-entry FIFO and arbitrates with bounded starvation.

Parameters:
- STARVE_LIMIT, 4, consecutive cycles a non-empty md FIFO may lose arbitration before the pipeline is back-pressured for one cycle (range 1..15).
- MD_FIFO_DEPTH, 2, md result buffer entries (power of two, ≥2).

Ports:
- `clk`  input  1  clock, all state rising-edge.
- `resetn`  input  1  asynchronous active-low reset.
- `wb_req_vld`  input  1  pipeline result valid.
- `wb_req_pkt`  input  wb_stg_pkg::wb_req_pkt_t  fields: addr[4:0], data word_t, ld_type ld_type_e, byte_off[1:0].
- `wb_req_rdy`  output  1  pipeline result accepted this cycle.
- `md_rsp_vld`  input  1  mul/div result valid.
- `md_rsp_pkt`  input  wb_stg_pkg::md_rsp_pkt_t  fields: addr[4:0], data word_t.
- `md_rsp_rdy`  output  1  FIFO can accept.
- `reg_file_wr_req_vld`  output  1  register write valid.
- `reg_file_wr_req_pkt`  output  reg_file_pkg::reg_file_wr_req_pkt_t  addr, data.

Behaviour:
- Reset (`resetn`=0, asynchronous):
  - FIFO empty, starve counter 0.
  - `reg_file_wr_req_vld`=0, `reg_file_wr_req_pkt`=0.
  - `md_rsp_rdy`=1 one cycle after reset release.
  - Reset mid-operation discards buffered md results.
- Load extraction (pipeline source only), big-endian. `byte_off`=0 selects bits [31:24].
  - LD_NONE: data passes unchanged (ALU result).
  - LD_W: data unchanged.
  - LD_H / LD_HU: `byte_off[1]`=0 → [31:16], =1 → [15:0]; sign- or zero-extend to 32. `byte_off[0]` is ignored; alignment faults are upstream's job.
  - LD_B / LD_BU: byte (3-`byte_off`)*8+7 : (3-`byte_off`)*8; sign- or zero-extend.
- FIFO:
  - `md_rsp_rdy` = count < MD_FIFO_DEPTH, from registered count only.
  - Push on `md_rsp_vld` && `md_rsp_rdy`.
  - A pushed entry is poppable no earlier than the next cycle (no bypass).
  - Push and pop in the same cycle keep count unchanged.
- Arbitration, evaluated each cycle:
  - starve_hit = (starve_cnt == STARVE_LIMIT) && fifo non-empty.
  - `wb_req_rdy` = !starve_hit.
  - Source select: pipeline if `wb_req_vld` && !starve_hit; else FIFO head if non-empty; else none.
  - starve_cnt: cleared on pop or when empty; else incremented when non-empty and not popped; saturates at STARVE_LIMIT.
- Output:
  - Registered; one cycle latency from accept/pop to `reg_file_wr_req_vld`.
  - `reg_file_wr_req_vld` <= selected source valid && addr != 0.
  - Writes to $0 are consumed (accepted/popped) but never issued.
  - pkt.addr/data register only when a write is issued; they hold otherwise.
- At most one register write per cycle. Both sources targeting the same addr resolve by issue order; the later write wins.

Decomposition:
- wb_stg_pkg:
  - ld_type_e {LD_NONE, LD_W, LD_H, LD_HU, LD_B, LD_BU};
  - wb_req_pkt_t, md_rsp_pkt_t (use mips_pkg::word_t);
  - STARVE_CNT_W constant.
- Sub-module wb_md_fifo:
  - parameterised depth;
  - push/pop, head data, count, full/empty;
  - async active-low reset.
- Extension logic: a function in wb_stg_pkg.

Test Plan:
- Reset then idle, no stimulus → `reg_file_wr_req_vld`=0 and pkt=0 every cycle; `md_rsp_rdy`=1.
- Loads, data 0x8012F0A5:
  - LD_B `byte_off` 0 → 0xFFFFFF80; LD_BU `byte_off` 3 → 0x000000A5;
  - LD_H `byte_off` 2 → 0xFFFFF0A5; LD_HU `byte_off` 0 → 0x00008012;
  - each appears one cycle after accept with its addr.
- Write to $0: pipeline addr 0 data 0xDEADBEEF → `wb_req_rdy`=1, no write issued. md addr 0 → popped, no write issued.
- Contention, STARVE_LIMIT=4: md result addr 7 pushed, pipeline valid every cycle → 4 pipeline writes, then `wb_req_rdy`=0 for exactly one cycle, write addr 7 issued next cycle, starve_cnt cleared.
- FIFO full: 2 md pushes while pipeline streams → `md_rsp_rdy`=0. A third `md_rsp_vld` is held until a pop; after it, data order is preserved (FIFO).
- Reset asserted with FIFO holding 2 entries → `reg_file_wr_req_vld` drops to 0 asynchronously; after release no stale md write ever appears.

Source files
------------

// File: rtl/mips_pkg.sv
// Core-wide basic types shared by the pipeline stages.
package mips_pkg;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/reg_file_pkg.sv
// Register file request types.
package reg_file_pkg;

  typedef struct packed {
    logic [4:0]      addr;
    mips_pkg::word_t data;
  } reg_file_wr_req_pkt_t;

endpackage

// File: rtl/wb_stg_pkg.sv
// Writeback stage types, constants and the big-endian load extraction helper.
package wb_stg_pkg;

  typedef enum logic [2:0] {
    LD_NONE,
    LD_W,
    LD_H,
    LD_HU,
    LD_B,
    LD_BU
  } ld_type_e;

  typedef struct packed {
    logic [4:0]      addr;
    mips_pkg::word_t data;
    ld_type_e        ld_type;
    logic [1:0]      byte_off;
  } wb_req_pkt_t;

  typedef struct packed {
    logic [4:0]      addr;
    mips_pkg::word_t data;
  } md_rsp_pkt_t;

  // Wide enough for the largest supported starvation limit (15).
  localparam int STARVE_CNT_W = 4;

  // Big-endian extraction: byte_off 0 addresses the most significant byte.
  // byte_off[0] is ignored for halfword loads; misalignment is trapped upstream.
  function automatic mips_pkg::word_t ld_extract(input mips_pkg::word_t data,
                                                 input ld_type_e        ld_type,
                                                 input logic [1:0]      byte_off);
    logic [15:0]     half_v;
    logic [7:0]      byte_v;
    mips_pkg::word_t res;
    half_v = byte_off[1] ? data[15:0] : data[31:16];
    case (byte_off)
      2'd0:    byte_v = data[31:24];
      2'd1:    byte_v = data[23:16];
      2'd2:    byte_v = data[15:8];
      default: byte_v = data[7:0];
    endcase
    case (ld_type)
      LD_H:    res = {{16{half_v[15]}}, half_v};
      LD_HU:   res = {16'h0000, half_v};
      LD_B:    res = {{24{byte_v[7]}}, byte_v};
      LD_BU:   res = {24'h000000, byte_v};
      default: res = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/wb_md_fifo.sv
// Small circular FIFO buffering multiply/divide results for the writeback stage.
// The head is only presented once an entry is registered, so there is no bypass.
module wb_md_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 37
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  // Next pointer/occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; reset empties the buffer and discards anything pending.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful while counted as occupied.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/wb_stg.sv
// Writeback stage: merges in-order pipeline results with buffered mul/div
// results into a single registered register-file write port.
module wb_stg
  import wb_stg_pkg::*;
#(
  parameter int STARVE_LIMIT  = 4,
  parameter int MD_FIFO_DEPTH = 2
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic                               wb_req_vld,
  input  wb_stg_pkg::wb_req_pkt_t            wb_req_pkt,
  output logic                               wb_req_rdy,
  input  logic                               md_rsp_vld,
  input  wb_stg_pkg::md_rsp_pkt_t            md_rsp_pkt,
  output logic                               md_rsp_rdy,
  output logic                               reg_file_wr_req_vld,
  output reg_file_pkg::reg_file_wr_req_pkt_t reg_file_wr_req_pkt
);

  localparam int MD_W  = $bits(md_rsp_pkt_t);
  localparam int CNT_W = $clog2(MD_FIFO_DEPTH + 1);

  logic [MD_W-1:0]   fifo_head;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              fifo_full, fifo_empty;
  md_rsp_pkt_t       md_head;

  logic              starve_hit, sel_pipe, md_pop, md_push;
  logic [4:0]        sel_addr;
  mips_pkg::word_t   sel_data;

  logic [STARVE_CNT_W-1:0]            starve_cnt_q, starve_cnt_d;
  logic                               wr_vld_q, wr_vld_d;
  reg_file_pkg::reg_file_wr_req_pkt_t wr_pkt_q, wr_pkt_d;

  wb_md_fifo #(
    .DEPTH (MD_FIFO_DEPTH),
    .W     (MD_W)
  ) u_md_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (md_push),
    .push_data (md_rsp_pkt),
    .pop       (md_pop),
    .head_data (fifo_head),
    .count     (fifo_cnt),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign md_head             = md_rsp_pkt_t'(fifo_head);
  assign md_rsp_rdy          = (fifo_cnt < CNT_W'(MD_FIFO_DEPTH));
  assign wb_req_rdy          = !starve_hit;
  assign reg_file_wr_req_vld = wr_vld_q;
  assign reg_file_wr_req_pkt = wr_pkt_q;

  // Arbitration: pipeline wins unless the md buffer has waited STARVE_LIMIT cycles.
  always_comb begin
    starve_hit = (starve_cnt_q == STARVE_CNT_W'(STARVE_LIMIT)) && !fifo_empty;
    sel_pipe   = wb_req_vld && !starve_hit;
    md_pop     = !sel_pipe && !fifo_empty;
    md_push    = md_rsp_vld && md_rsp_rdy && !fifo_full;

    if (md_pop || fifo_empty)
      starve_cnt_d = '0;
    else if (starve_cnt_q != STARVE_CNT_W'(STARVE_LIMIT))
      starve_cnt_d = starve_cnt_q + STARVE_CNT_W'(1);
    else
      starve_cnt_d = starve_cnt_q;

    sel_addr = sel_pipe ? wb_req_pkt.addr : md_head.addr;
    sel_data = sel_pipe ? ld_extract(wb_req_pkt.data, wb_req_pkt.ld_type, wb_req_pkt.byte_off)
                        : md_head.data;

    // Writes to $0 are consumed but never reach the register file.
    wr_vld_d = (sel_pipe || md_pop) && (sel_addr != 5'd0);
    wr_pkt_d = wr_pkt_q;
    if (wr_vld_d) begin
      wr_pkt_d.addr = sel_addr;
      wr_pkt_d.data = sel_data;
    end
  end

  // Registered write port and starvation counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt_q <= '0;
      wr_vld_q     <= 1'b0;
      wr_pkt_q     <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      wr_vld_q     <= wr_vld_d;
      wr_pkt_q     <= wr_pkt_d;
    end
  end

endmodule

// File: tb/tb_wb_stg.sv
// Testbench for wb_stg: load extraction table, $0 writes, starvation,
// FIFO-full back-pressure and asynchronous reset with buffered md results.
module tb_wb_stg;
  import wb_stg_pkg::*;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    ld_type_e    lt;
    logic [1:0]  off;
    logic [31:0] din;
    logic [4:0]  addr;
    logic [31:0] exp;
  } ld_vec_t;

  logic                               clk;
  logic                               resetn;
  logic                               wb_req_vld;
  wb_req_pkt_t                        wb_req_pkt;
  logic                               wb_req_rdy;
  logic                               md_rsp_vld;
  md_rsp_pkt_t                        md_rsp_pkt;
  logic                               md_rsp_rdy;
  logic                               reg_file_wr_req_vld;
  reg_file_pkg::reg_file_wr_req_pkt_t reg_file_wr_req_pkt;

  int  checks = 0;
  int  errors = 0;
  wr_t sb_q[$];
  wr_t mon_e;

  wb_stg #(.STARVE_LIMIT(4), .MD_FIFO_DEPTH(2)) dut (
    .clk                 (clk),
    .resetn              (resetn),
    .wb_req_vld          (wb_req_vld),
    .wb_req_pkt          (wb_req_pkt),
    .wb_req_rdy          (wb_req_rdy),
    .md_rsp_vld          (md_rsp_vld),
    .md_rsp_pkt          (md_rsp_pkt),
    .md_rsp_rdy          (md_rsp_rdy),
    .reg_file_wr_req_vld (reg_file_wr_req_vld),
    .reg_file_wr_req_pkt (reg_file_wr_req_pkt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic wb_req_pkt_t wp(input logic [4:0] a, input logic [31:0] d,
                                     input ld_type_e lt = LD_NONE, input logic [1:0] off = 2'd0);
    wb_req_pkt_t p;
    p.addr = a; p.data = d; p.ld_type = lt; p.byte_off = off;
    return p;
  endfunction

  function automatic md_rsp_pkt_t mp(input logic [4:0] a, input logic [31:0] d);
    md_rsp_pkt_t p;
    p.addr = a; p.data = d;
    return p;
  endfunction

  task automatic ex(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a; e.data = d;
    sb_q.push_back(e);
  endtask

  // One clock cycle of stimulus; the ready outputs are compared to hand-derived values.
  task automatic step(input bit pv, input wb_req_pkt_t pp, input bit mv, input md_rsp_pkt_t mpk,
                      input bit ew, input bit em, input string tag);
    @(negedge clk);
    #1;
    wb_req_vld = pv; wb_req_pkt = pp; md_rsp_vld = mv; md_rsp_pkt = mpk;
    #1;
    chk({tag, "_wb_rdy"}, 64'(wb_req_rdy), 64'(ew));
    chk({tag, "_md_rdy"}, 64'(md_rsp_rdy), 64'(em));
  endtask

  task automatic idle(input bit em, input string tag);
    step(1'b0, '0, 1'b0, '0, 1'b1, em, tag);
  endtask

  // Scoreboard: every issued write must match the next expected write in order.
  always @(negedge clk) begin
    if (resetn === 1'b1 && reg_file_wr_req_vld === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, no write expected",
                 reg_file_wr_req_pkt.addr, reg_file_wr_req_pkt.data);
      end else begin
        mon_e = sb_q.pop_front();
        if (reg_file_wr_req_pkt.addr !== mon_e.addr || reg_file_wr_req_pkt.data !== mon_e.data) begin
          errors++;
          $display("FAIL wr_pkt: got addr=%0d data=%h expected addr=%0d data=%h",
                   reg_file_wr_req_pkt.addr, reg_file_wr_req_pkt.data, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  ld_vec_t lv[14];

  initial begin
    lv[0]  = '{LD_B,    2'd0, 32'h8012F0A5, 5'd1,  32'hFFFFFF80};
    lv[1]  = '{LD_BU,   2'd3, 32'h8012F0A5, 5'd2,  32'h000000A5};
    lv[2]  = '{LD_H,    2'd2, 32'h8012F0A5, 5'd3,  32'hFFFFF0A5};
    lv[3]  = '{LD_HU,   2'd0, 32'h8012F0A5, 5'd4,  32'h00008012};
    lv[4]  = '{LD_W,    2'd0, 32'h8012F0A5, 5'd5,  32'h8012F0A5};
    lv[5]  = '{LD_NONE, 2'd2, 32'h8012F0A5, 5'd6,  32'h8012F0A5};
    lv[6]  = '{LD_B,    2'd1, 32'h8012F0A5, 5'd7,  32'h00000012};
    lv[7]  = '{LD_B,    2'd2, 32'h8012F0A5, 5'd8,  32'hFFFFFFF0};
    lv[8]  = '{LD_BU,   2'd0, 32'h8012F0A5, 5'd9,  32'h00000080};
    lv[9]  = '{LD_BU,   2'd2, 32'h8012F0A5, 5'd10, 32'h000000F0};
    lv[10] = '{LD_H,    2'd3, 32'h8012F0A5, 5'd11, 32'hFFFFF0A5};
    lv[11] = '{LD_H,    2'd1, 32'h8012F0A5, 5'd12, 32'hFFFF8012};
    lv[12] = '{LD_HU,   2'd2, 32'h8012F0A5, 5'd13, 32'h0000F0A5};
    lv[13] = '{LD_B,    2'd3, 32'h0000007F, 5'd14, 32'h0000007F};

    resetn = 1'b0;
    wb_req_vld = 1'b0; wb_req_pkt = '0; md_rsp_vld = 1'b0; md_rsp_pkt = '0;
    #3;
    chk("rst_vld", 64'(reg_file_wr_req_vld), 64'd0);
    chk("rst_pkt", 64'(reg_file_wr_req_pkt), 64'd0);
    repeat (3) @(negedge clk);
    #1 resetn = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 5; i++) begin
      idle(1'b1, "idle");
      chk("idle_vld", 64'(reg_file_wr_req_vld), 64'd0);
      chk("idle_pkt", 64'(reg_file_wr_req_pkt), 64'd0);
    end

    // Load extraction table, back to back.
    for (int i = 0; i < 14; i++) begin
      ex(lv[i].addr, lv[i].exp);
      step(1'b1, wp(lv[i].addr, lv[i].din, lv[i].lt, lv[i].off), 1'b0, '0, 1'b1, 1'b1, "ld");
    end
    idle(1'b1, "ld_drain");
    idle(1'b1, "ld_drain");

    // Pipeline write to $0: accepted, never issued.
    step(1'b1, wp(5'd0, 32'hDEADBEEF), 1'b0, '0, 1'b1, 1'b1, "z_pipe");
    idle(1'b1, "z_pipe_out");
    chk("z_pipe_vld", 64'(reg_file_wr_req_vld), 64'd0);

    // md write to $0: pushed, popped next cycle, never issued.
    step(1'b0, '0, 1'b1, mp(5'd0, 32'h12345678), 1'b1, 1'b1, "z_md");
    idle(1'b1, "z_md_pop");
    idle(1'b1, "z_md_out");
    chk("z_md_vld", 64'(reg_file_wr_req_vld), 64'd0);
    idle(1'b1, "z_md_after");
    chk("z_md_vld2", 64'(reg_file_wr_req_vld), 64'd0);

    // FIFO full while the pipeline streams; the third md result waits for a pop.
    ex(5'd1, 32'h1000); ex(5'd2, 32'h1001); ex(5'd3, 32'h1002); ex(5'd4, 32'h1003);
    ex(5'd5, 32'h1004); ex(5'd11, 32'hA0); ex(5'd6, 32'h1005); ex(5'd12, 32'hA1);
    ex(5'd13, 32'hA2);
    step(1'b1, wp(5'd1, 32'h1000), 1'b1, mp(5'd11, 32'hA0), 1'b1, 1'b1, "ff0");
    step(1'b1, wp(5'd2, 32'h1001), 1'b1, mp(5'd12, 32'hA1), 1'b1, 1'b1, "ff1");
    step(1'b1, wp(5'd3, 32'h1002), 1'b1, mp(5'd13, 32'hA2), 1'b1, 1'b0, "ff2");
    step(1'b1, wp(5'd4, 32'h1003), 1'b1, mp(5'd13, 32'hA2), 1'b1, 1'b0, "ff3");
    step(1'b1, wp(5'd5, 32'h1004), 1'b1, mp(5'd13, 32'hA2), 1'b1, 1'b0, "ff4");
    step(1'b1, wp(5'd6, 32'h1005), 1'b1, mp(5'd13, 32'hA2), 1'b0, 1'b0, "ff5");
    step(1'b1, wp(5'd6, 32'h1005), 1'b1, mp(5'd13, 32'hA2), 1'b1, 1'b1, "ff6");
    idle(1'b0, "ff7");
    idle(1'b1, "ff8");
    idle(1'b1, "ff9");
    idle(1'b1, "ff10");
    chk("ff_sb_empty", 64'(sb_q.size()), 64'd0);

    // Starvation bound: md result pushed, then four pipeline writes, one stall.
    ex(5'd20, 32'h2000); ex(5'd21, 32'h2001); ex(5'd22, 32'h2002); ex(5'd23, 32'h2003);
    ex(5'd7, 32'h77770007); ex(5'd24, 32'h2004);
    step(1'b0, '0, 1'b1, mp(5'd7, 32'h77770007), 1'b1, 1'b1, "st0");
    for (int i = 0; i < 4; i++)
      step(1'b1, wp(5'(20 + i), 32'(32'h2000 + i)), 1'b0, '0, 1'b1, 1'b1, "st_pipe");
    step(1'b1, wp(5'd24, 32'h2004), 1'b0, '0, 1'b0, 1'b1, "st_stall");
    step(1'b1, wp(5'd24, 32'h2004), 1'b0, '0, 1'b1, 1'b1, "st_resume");
    chk("st_md_vld", 64'(reg_file_wr_req_vld), 64'd1);
    chk("st_md_addr", 64'(reg_file_wr_req_pkt.addr), 64'd7);
    idle(1'b1, "st_drain");
    idle(1'b1, "st_drain");
    chk("st_sb_empty", 64'(sb_q.size()), 64'd0);

    // Reset with two md results buffered behind a streaming pipeline.
    ex(5'd16, 32'h3000); ex(5'd17, 32'h3001); ex(5'd18, 32'h3002);
    step(1'b1, wp(5'd16, 32'h3000), 1'b1, mp(5'd14, 32'hBAD0), 1'b1, 1'b1, "rs0");
    step(1'b1, wp(5'd17, 32'h3001), 1'b1, mp(5'd15, 32'hBAD1), 1'b1, 1'b1, "rs1");
    step(1'b1, wp(5'd18, 32'h3002), 1'b0, '0, 1'b1, 1'b0, "rs2");
    @(negedge clk);
    #2;
    chk("rs_pre_vld", 64'(reg_file_wr_req_vld), 64'd1);
    resetn = 1'b0;
    wb_req_vld = 1'b0; wb_req_pkt = '0; md_rsp_vld = 1'b0; md_rsp_pkt = '0;
    #1;
    chk("rs_async_vld", 64'(reg_file_wr_req_vld), 64'd0);
    chk("rs_async_pkt", 64'(reg_file_wr_req_pkt), 64'd0);
    chk("rs_sb_empty", 64'(sb_q.size()), 64'd0);
    repeat (2) @(negedge clk);
    #1 resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      idle(1'b1, "rs_idle");
      chk("rs_idle_vld", 64'(reg_file_wr_req_vld), 64'd0);
    end

    chk("final_sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
